// File: rtl/btn_conditioner.sv
// Pushbutton front end: synchronises and debounces raw buttons and the mode
// switch, then turns them into single-cycle command pulses with up/down repeat.

module btn_repeat #(
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 10000000,
    parameter int CNT_W        = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    input  logic rise,
    output logic pulse_next
);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

    rep_state_t       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // A release always wins over a pending timer expiry in the same cycle.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        pulse_next = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    pulse_next = 1'b1;
                    timer_d    = '0;
                    state_d    = DELAY;
                end
            end
            DELAY: begin
                if (!level) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else if (timer_q == CNT_W'(REPEAT_DELAY - 1)) begin
                    pulse_next = 1'b1;
                    timer_d    = '0;
                    state_d    = REPEAT;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (!level) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else if (timer_q == CNT_W'(REPEAT_RATE - 1)) begin
                    pulse_next = 1'b1;
                    timer_d    = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000,
    parameter int CNT_W           = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    input  logic btn_left_raw,
    input  logic btn_right_raw,
    input  logic btn_center_raw,
    input  logic sw_mode_raw,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic pressed,
    output logic mode,
    output logic any_held
);

    localparam int N = 6;

    // Bit order: 0 up, 1 down, 2 left, 3 right, 4 centre, 5 mode switch.
    logic [N-1:0]     raw, sync1, sync2, stable, stable_d, rise;
    logic [CNT_W-1:0] cnt [N];
    logic             up_nx, down_nx;

    assign raw = {sw_mode_raw, btn_center_raw, btn_right_raw,
                  btn_left_raw, btn_down_raw, btn_up_raw};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < N; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = stable & ~stable_d;

    btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .CNT_W(CNT_W))
        u_rep_up (.clk(clk), .rst(rst), .level(stable[0]), .rise(rise[0]), .pulse_next(up_nx));

    btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .CNT_W(CNT_W))
        u_rep_down (.clk(clk), .rst(rst), .level(stable[1]), .rise(rise[1]), .pulse_next(down_nx));

    // Up beats down and left beats right; only the losing pulse is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up      <= 1'b0;
            down    <= 1'b0;
            left    <= 1'b0;
            right   <= 1'b0;
            pressed <= 1'b0;
        end else begin
            up      <= up_nx;
            down    <= down_nx & ~up_nx;
            left    <= rise[2];
            right   <= rise[3] & ~rise[2];
            pressed <= rise[4];
        end
    end

    assign mode     = stable[5];
    assign any_held = |stable[4:0];

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat parameters;
// expected pulse cycles are counted in clocks from the input change.

module tb_btn_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic btn_up_raw, btn_down_raw, btn_left_raw, btn_right_raw, btn_center_raw, sw_mode_raw;
    logic up, down, left, right, pressed, mode, any_held;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20),
        .REPEAT_RATE(8),
        .CNT_W(27)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_up_raw(btn_up_raw), .btn_down_raw(btn_down_raw),
        .btn_left_raw(btn_left_raw), .btn_right_raw(btn_right_raw),
        .btn_center_raw(btn_center_raw), .sw_mode_raw(sw_mode_raw),
        .up(up), .down(down), .left(left), .right(right),
        .pressed(pressed), .mode(mode), .any_held(any_held)
    );

    // Advance one clock and settle just after the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int cyc, input logic observed, input logic expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $display("[TB] FAIL %s cycle %0d: observed=%b expected=%b", tag, cyc, observed, expected);
            $error("[TB] %s cycle %0d: observed=%b expected=%b", tag, cyc, observed, expected);
        end
    endtask

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) applyStimulus();
    endtask

    initial begin
        rst = 1'b1;
        btn_up_raw = 0; btn_down_raw = 0; btn_left_raw = 0;
        btn_right_raw = 0; btn_center_raw = 0; sw_mode_raw = 0;
        settle(3);
        checkOutput("reset_up", 0, up, 1'b0);
        checkOutput("reset_down", 0, down, 1'b0);
        checkOutput("reset_left", 0, left, 1'b0);
        checkOutput("reset_right", 0, right, 1'b0);
        checkOutput("reset_pressed", 0, pressed, 1'b0);
        checkOutput("reset_mode", 0, mode, 1'b0);
        checkOutput("reset_any_held", 0, any_held, 1'b0);
        rst = 1'b0;
        settle(3);

        $display("[TB] clean left press");
        btn_left_raw = 1;
        for (int k = 1; k <= 50; k++) begin
            applyStimulus();
            checkOutput("left_pulse", k, left, k == 7);
            checkOutput("left_any_held", k, any_held, k >= 6);
            checkOutput("left_no_right", k, right, 1'b0);
        end
        btn_left_raw = 0;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus();
            checkOutput("left_release", k, left, 1'b0);
            checkOutput("left_release_held", k, any_held, k < 6);
        end

        $display("[TB] bouncing centre press");
        btn_center_raw = 1; applyStimulus(); checkOutput("bounce_early", 1, pressed, 1'b0);
        btn_center_raw = 0; applyStimulus(); checkOutput("bounce_early", 2, pressed, 1'b0);
        btn_center_raw = 1; applyStimulus(); checkOutput("bounce_early", 3, pressed, 1'b0);
        btn_center_raw = 0; applyStimulus(); checkOutput("bounce_early", 4, pressed, 1'b0);
        btn_center_raw = 1;
        for (int k = 1; k <= 15; k++) begin
            applyStimulus();
            checkOutput("bounce_pressed", k, pressed, k == 7);
        end
        btn_center_raw = 0;
        settle(12);
        btn_center_raw = 1;
        settle(3);
        btn_center_raw = 0;
        for (int k = 1; k <= 15; k++) begin
            applyStimulus();
            checkOutput("glitch_pressed", k, pressed, 1'b0);
            checkOutput("glitch_any_held", k, any_held, 1'b0);
        end

        $display("[TB] up auto-repeat, held 40 cycles");
        btn_up_raw = 1;
        for (int k = 1; k <= 60; k++) begin
            if (k == 41) btn_up_raw = 0;
            applyStimulus();
            checkOutput("repeat_up", k, up, (k == 7) || (k == 27) || (k == 35) || (k == 43));
            checkOutput("repeat_no_down", k, down, 1'b0);
        end

        $display("[TB] up/down collision");
        btn_up_raw = 1; btn_down_raw = 1;
        for (int k = 1; k <= 55; k++) begin
            if (k == 11) btn_up_raw = 0;
            if (k == 41) btn_down_raw = 0;
            applyStimulus();
            checkOutput("collide_up", k, up, k == 7);
            checkOutput("collide_down", k, down, (k == 27) || (k == 35) || (k == 43));
        end

        $display("[TB] left/right collision");
        btn_left_raw = 1; btn_right_raw = 1;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus();
            checkOutput("collide_left", k, left, k == 7);
            checkOutput("collide_right", k, right, 1'b0);
        end
        btn_left_raw = 0; btn_right_raw = 0;
        settle(12);

        $display("[TB] reset during down hold");
        btn_down_raw = 1;
        for (int k = 1; k <= 25; k++) begin
            applyStimulus();
            checkOutput("rst_hold_down", k, down, k == 7);
        end
        rst = 1'b1;
        #1;
        checkOutput("rst_async_down", 25, down, 1'b0);
        checkOutput("rst_async_any_held", 25, any_held, 1'b0);
        settle(3);
        checkOutput("rst_still_down", 28, down, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            applyStimulus();
            checkOutput("rst_fresh_down", k, down, k == 7);
        end
        btn_down_raw = 0;
        settle(12);

        $display("[TB] mode switch");
        sw_mode_raw = 1;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus();
            checkOutput("mode_rise", k, mode, k >= 6);
        end
        sw_mode_raw = 0;
        settle(2);
        sw_mode_raw = 1;
        for (int k = 1; k <= 12; k++) begin
            applyStimulus();
            checkOutput("mode_glitch", k, mode, 1'b1);
            checkOutput("mode_no_held", k, any_held, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
